// File: rtl/alu_npu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_npu_seq
// Purpose  : Handshaked ALU/NPU tile with a generic operand width. Handles one
//            operation at a time. Single-cycle ops go straight to the output
//            register. DIV/MOD run a restoring divider for WIDTH cycles. NPU
//            mode keeps a saturating multiply-accumulate register.
// Ports    : clk, rst (async, active-high)
//            in_valid / in_ready   - request handshake (a, b, opcode, mode)
//            out_valid / out_ready - result handshake (result, zero, carry,
//                                    sign, error)
//            busy                  - divider iterating
// Options  : ALU_SATURATE_EN - ALU ADD/SUB/MUL clamp instead of wrapping
// Revision : 1.0 - initial release
// ============================================================================
module alu_npu_seq #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             error,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // State encoding and opcodes
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_MUL  = 4'd2;
    localparam logic [3:0] c_OP_DIV  = 4'd3;
    localparam logic [3:0] c_OP_MOD  = 4'd4;
    localparam logic [3:0] c_OP_ROL  = 4'd5;
    localparam logic [3:0] c_OP_ROR  = 4'd6;
    localparam logic [3:0] c_OP_AND  = 4'd7;
    localparam logic [3:0] c_OP_OR   = 4'd8;
    localparam logic [3:0] c_OP_XOR  = 4'd9;
    localparam logic [3:0] c_OP_NOT  = 4'd10;
    localparam logic [3:0] c_OP_GT   = 4'd11;
    localparam logic [3:0] c_OP_EQ   = 4'd12;
    localparam logic [3:0] c_OP_LOP  = 4'd13;

    localparam logic [3:0] c_NP_MAC    = 4'd0;
    localparam logic [3:0] c_NP_READ   = 4'd1;
    localparam logic [3:0] c_NP_CLEAR  = 4'd2;
    localparam logic [3:0] c_NP_RELU   = 4'd3;
    localparam logic [3:0] c_NP_MAX    = 4'd4;
    localparam logic [3:0] c_NP_MIN    = 4'd5;
    localparam logic [3:0] c_NP_THRESH = 4'd6;
    localparam logic [3:0] c_NP_XNOR   = 4'd7;
    localparam logic [3:0] c_NP_AVG    = 4'd8;

    localparam int               c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_WIDTH_V  = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] c_ONES     = '1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_sign;
    logic               r_error;
    logic [ACC_W-1:0]   r_acc;

    // Divider: r_quot starts as the dividend and is shifted out MSB-first
    // while quotient bits are shifted in at the bottom.
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_divisor;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_div_mod;

    // ------------------------------------------------------------------------
    // Handshake and status
    // ------------------------------------------------------------------------
    logic w_accept;
    logic w_is_div;
    logic w_b_nz;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state == S_DIV);
    assign w_accept  = in_valid && in_ready;
    assign w_is_div  = !mode && ((opcode == c_OP_DIV) || (opcode == c_OP_MOD));
    assign w_b_nz    = (b != '0);

    assign result = r_result;
    assign zero   = r_zero;
    assign carry  = r_carry;
    assign sign   = r_sign;
    assign error  = r_error;

    // ------------------------------------------------------------------------
    // Shared arithmetic
    // ------------------------------------------------------------------------
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_borrow;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_hi;
    logic [WIDTH-1:0]   w_sh;
    logic [WIDTH-1:0]   w_rol;
    logic [WIDTH-1:0]   w_ror;
    logic [ACC_W:0]     w_mac_sum;
    logic [ACC_W-1:0]   w_mac_acc;
    logic               w_mac_ovf;
    logic               w_rd_ovf;
    logic [WIDTH-1:0]   w_lop;

    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_diff   = a - b;
    assign w_borrow = (a < b);
    assign w_prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_mul_hi = |w_prod[2*WIDTH-1:WIDTH];

    // A shift by WIDTH yields zero, so sh == 0 degenerates cleanly to a.
    assign w_sh  = b % c_WIDTH_V;
    assign w_rol = (a << w_sh) | (a >> (c_WIDTH_V - w_sh));
    assign w_ror = (a >> w_sh) | (a << (c_WIDTH_V - w_sh));

    // One extra bit catches accumulator overflow before clamping.
    assign w_mac_sum = {1'b0, r_acc} + {{(ACC_W + 1 - 2 * WIDTH){1'b0}}, w_prod};
    assign w_mac_acc = w_mac_sum[ACC_W] ? '1 : w_mac_sum[ACC_W-1:0];
    assign w_mac_ovf = |w_mac_acc[ACC_W-1:WIDTH];
    assign w_rd_ovf  = |r_acc[ACC_W-1:WIDTH];

    always_comb begin
        w_lop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) begin
                w_lop = WIDTH'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Single-cycle result selection
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_err;
    logic             w_acc_we;
    logic [ACC_W-1:0] w_acc_nxt;

    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_err     = 1'b0;
        w_acc_we  = 1'b0;
        w_acc_nxt = r_acc;
        if (!mode) begin
            case (opcode)
                c_OP_ADD: begin
                    w_carry = w_sum[WIDTH];
`ifdef ALU_SATURATE_EN
                    w_res   = w_sum[WIDTH] ? c_ONES : w_sum[WIDTH-1:0];
`else
                    w_res   = w_sum[WIDTH-1:0];
`endif
                end
                c_OP_SUB: begin
                    w_carry = w_borrow;
`ifdef ALU_SATURATE_EN
                    w_res   = w_borrow ? '0 : w_diff;
`else
                    w_res   = w_diff;
`endif
                end
                c_OP_MUL: begin
                    w_carry = w_mul_hi;
`ifdef ALU_SATURATE_EN
                    w_res   = w_mul_hi ? c_ONES : w_prod[WIDTH-1:0];
`else
                    w_res   = w_prod[WIDTH-1:0];
`endif
                end
                // Only reached here with b == 0; non-zero divisors use the divider.
                c_OP_DIV, c_OP_MOD: begin
                    w_res = c_ONES;
                    w_err = 1'b1;
                end
                c_OP_ROL: w_res = w_rol;
                c_OP_ROR: w_res = w_ror;
                c_OP_AND: w_res = a & b;
                c_OP_OR:  w_res = a | b;
                c_OP_XOR: w_res = a ^ b;
                c_OP_NOT: w_res = ~a;
                c_OP_GT:  w_res = {{(WIDTH - 1){1'b0}}, (a > b)};
                c_OP_EQ:  w_res = {{(WIDTH - 1){1'b0}}, (a == b)};
                c_OP_LOP: begin
                    if (a == '0) begin
                        w_res = c_ONES;
                        w_err = 1'b1;
                    end else begin
                        w_res = w_lop;
                    end
                end
                default: w_err = 1'b1;
            endcase
        end else begin
            case (opcode)
                c_NP_MAC: begin
                    w_acc_we  = 1'b1;
                    w_acc_nxt = w_mac_acc;
                    w_carry   = w_mac_ovf;
                    w_res     = w_mac_ovf ? c_ONES : w_mac_acc[WIDTH-1:0];
                end
                c_NP_READ: begin
                    w_carry = w_rd_ovf;
                    w_res   = w_rd_ovf ? c_ONES : r_acc[WIDTH-1:0];
                end
                c_NP_CLEAR: begin
                    w_acc_we  = 1'b1;
                    w_acc_nxt = '0;
                end
                c_NP_RELU:   w_res = (a > b) ? w_diff : '0;
                c_NP_MAX:    w_res = (a > b) ? a : b;
                c_NP_MIN:    w_res = (a < b) ? a : b;
                c_NP_THRESH: w_res = (a > b) ? c_ONES : '0;
                c_NP_XNOR:   w_res = ~(a ^ b);
                c_NP_AVG:    w_res = w_sum[WIDTH:1];
                default:     w_err = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Restoring divider step
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_trial;
    logic [WIDTH-1:0] w_quot_nxt;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_div_res;

    assign w_div_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_divisor};

    always_comb begin
        if (!w_div_trial[WIDTH]) begin
            w_rem_nxt  = w_div_trial[WIDTH-1:0];
            w_quot_nxt = {r_quot[WIDTH-2:0], 1'b1};
        end else begin
            w_rem_nxt  = w_div_shift[WIDTH-1:0];
            w_quot_nxt = {r_quot[WIDTH-2:0], 1'b0};
        end
    end

    assign w_div_res = r_div_mod ? w_rem_nxt : w_quot_nxt;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (w_is_div && w_b_nz) ? S_DIV : S_OUT;
                end
            end
            S_DIV: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_sign    <= 1'b0;
            r_error   <= 1'b0;
            r_acc     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_div_mod <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_div && w_b_nz) begin
                            r_quot    <= a;
                            r_rem     <= '0;
                            r_divisor <= b;
                            r_cnt     <= '0;
                            r_div_mod <= (opcode == c_OP_MOD);
                        end else begin
                            r_result <= w_res;
                            r_zero   <= (w_res == '0);
                            r_sign   <= w_res[WIDTH-1];
                            r_carry  <= w_carry;
                            r_error  <= w_err;
                        end
                        if (w_acc_we) begin
                            r_acc <= w_acc_nxt;
                        end
                    end
                end
                S_DIV: begin
                    r_quot <= w_quot_nxt;
                    r_rem  <= w_rem_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    // Final iteration writes the output register directly.
                    if (r_cnt == c_CNT_LAST) begin
                        r_result <= w_div_res;
                        r_zero   <= (w_div_res == '0);
                        r_sign   <= w_div_res[WIDTH-1];
                        r_carry  <= 1'b0;
                        r_error  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
